// File: rtl/sdram_cmd_monitor.sv
// SDRAM command-bus monitor: decodes commands sampled on the pins, tracks open banks,
// counts refreshes and flags tRP / tRFC / refresh-interval / bank-state violations.
// Passive: it only observes the bus and never drives it.
module sdram_cmd_monitor #(
  parameter int unsigned ASIZE  = 13,
  parameter int unsigned T_RP   = 2,
  parameter int unsigned T_RFC  = 7,
  parameter int unsigned T_REFI = 1560
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Cs_n,
  input  logic             Ras_n,
  input  logic             Cas_n,
  input  logic             We_n,
  input  logic [1:0]       Ba,
  input  logic [ASIZE-1:0] Sa,
  input  logic             err_clr,
  output logic             pre_p,
  output logic             aref_p,
  output logic             act_p,
  output logic             rd_p,
  output logic             wr_p,
  output logic             lmr_p,
  output logic [3:0]       bank_open,
  output logic [15:0]      ref_cnt,
  output logic             err_rp,
  output logic             err_rfc,
  output logic             err_aref_open,
  output logic             err_act_open,
  output logic             err_refi
);

  localparam int unsigned RefiW = (T_REFI < 2) ? 1 : $clog2(T_REFI + 1);
  localparam logic [RefiW-1:0] RefiMax  = RefiW'(T_REFI);
  localparam logic [15:0]      TrpLoad  = 16'(T_RP - 1);
  localparam logic [15:0]      TrfcLoad = 16'(T_RFC - 1);

  typedef enum logic [1:0] {StIdle, StPrech, StRefr} state_e;

  state_e           state_q, state_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [RefiW-1:0] refi_q, refi_d;
  logic [5:0]       pulse_q, pulse_d;   // {pre, aref, act, rd, wr, lmr}
  logic [3:0]       bank_q, bank_d;
  logic [15:0]      ref_q, ref_d;
  logic [4:0]       err_q, err_d;       // {rp, rfc, aref_open, act_open, refi}

  logic [3:0] cmd;
  logic is_lmr, is_aref, is_pre, is_act, is_wr, is_rd, busy_cmd;
  logic [4:0] err_set;

  // Only Sa[10] matters here; the rest of the address bus is deliberately ignored.
  logic unused_sa;
  assign unused_sa = ^Sa;

  // Command decode; Cs_n is part of each pattern, so INH never matches.
  always_comb begin
    cmd      = {Cs_n, Ras_n, Cas_n, We_n};
    is_lmr   = (cmd == 4'b0000);
    is_aref  = (cmd == 4'b0001);
    is_pre   = (cmd == 4'b0010);
    is_act   = (cmd == 4'b0011);
    is_wr    = (cmd == 4'b0100);
    is_rd    = (cmd == 4'b0101);
    // BST, NOP and INH count as idle for timing checks
    busy_cmd = is_lmr | is_aref | is_pre | is_act | is_wr | is_rd;
  end

  // Timing FSM next state: count down, then let a PRE/AREF (even a violating one) reload.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StIdle: ;
      StPrech, StRefr: begin
        if (tmr_q <= 16'd1) begin
          state_d = StIdle;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
    if (is_pre) begin
      tmr_d   = TrpLoad;
      state_d = (TrpLoad == 16'd0) ? StIdle : StPrech;
    end else if (is_aref) begin
      tmr_d   = TrfcLoad;
      state_d = (TrfcLoad == 16'd0) ? StIdle : StRefr;
    end
  end

  // Bank state, refresh counters, pulses and sticky error flags.
  always_comb begin
    bank_d = bank_q;
    if (is_act) begin
      bank_d[Ba] = 1'b1;
    end else if (is_pre) begin
      if (Sa[10]) begin
        bank_d = '0;
      end else begin
        bank_d[Ba] = 1'b0;
      end
    end

    ref_d = is_aref ? ref_q + 16'd1 : ref_q;

    refi_d = refi_q;
    if (is_aref) begin
      refi_d = '0;
    end else if (refi_q != RefiMax) begin
      refi_d = refi_q + 1'b1;
    end

    pulse_d = {is_pre, is_aref, is_act, is_rd, is_wr, is_lmr};

    err_set[4] = (state_q == StPrech) && busy_cmd;
    err_set[3] = (state_q == StRefr) && busy_cmd;
    err_set[2] = is_aref && (bank_q != 4'b0000);
    err_set[1] = is_act && bank_q[Ba];
    // Fires only on the step that reaches the limit, not while saturated
    err_set[0] = !is_aref && (refi_q == RefiMax - 1'b1);

    // A set in the same clock as err_clr takes priority
    err_d = (err_q & {5{~err_clr}}) | err_set;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      refi_q  <= '0;
      pulse_q <= '0;
      bank_q  <= '0;
      ref_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      refi_q  <= refi_d;
      pulse_q <= pulse_d;
      bank_q  <= bank_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
    end
  end

  assign {pre_p, aref_p, act_p, rd_p, wr_p, lmr_p}               = pulse_q;
  assign bank_open                                               = bank_q;
  assign ref_cnt                                                 = ref_q;
  assign {err_rp, err_rfc, err_aref_open, err_act_open, err_refi} = err_q;

endmodule
